// File: rtl/stream_mux_arb.sv
// N:1 valid/ready stream multiplexer with a registered output stage and a per-cycle grant.
// Define STREAM_MUX_ARB_RR_EN for round-robin arbitration; otherwise the lowest-index valid channel wins.
module stream_mux_arb #(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           man_en,
  input  logic [CW-1:0]  man_sel,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [W-1:0]  w_chan_data [N];
  logic [N-1:0]  w_grant;
  logic [CW-1:0] w_gidx;
  logic          w_load;
  logic          w_accept;

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_chan;
  logic          r_valid;
`ifdef STREAM_MUX_ARB_RR_EN
  logic [CW-1:0] r_ptr;
`endif

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign w_chan_data[gi] = in_data[gi*W +: W];
    end
  endgenerate

  // The output register may take a new word whenever it is empty or being drained this cycle.
  assign w_load   = ~r_valid | out_ready;
  assign in_ready = w_grant & {N{w_load & ~rst}};
  assign w_accept = |in_ready;

  always_comb begin : p_grant
    int            base;
    logic          found;
    logic [CW-1:0] idx;
    w_grant = '0;
    w_gidx  = '0;
    found   = 1'b0;
    idx     = '0;
`ifdef STREAM_MUX_ARB_RR_EN
    base = int'(r_ptr);
`else
    base = 0;
`endif
    if (man_en) begin
      if ({1'b0, man_sel} < (CW+1)'(N)) begin
        w_grant[man_sel] = in_valid[man_sel];
        w_gidx           = man_sel;
      end
    end else begin
      // Scan channels starting at the base index, wrapping past N-1; first valid one wins.
      for (int k = 0; k < N; k++) begin
        idx = CW'((base + k) % N);
        if (!found && in_valid[idx]) begin
          found        = 1'b1;
          w_grant[idx] = 1'b1;
          w_gidx       = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
`ifdef STREAM_MUX_ARB_RR_EN
      r_ptr   <= '0;
`endif
    end else if (w_accept) begin
      r_data  <= w_chan_data[w_gidx];
      r_chan  <= w_gidx;
      r_valid <= 1'b1;
`ifdef STREAM_MUX_ARB_RR_EN
      // Manual-mode transfers leave the fairness pointer alone.
      if (!man_en) begin
        r_ptr <= (w_gidx == CW'(N-1)) ? '0 : w_gidx + 1'b1;
      end
`endif
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model of the arbitration rules.
module tb_stream_mux_arb;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int CW = $clog2(N);
`ifdef STREAM_MUX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           man_en;
  logic [CW-1:0]  man_sel;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  logic [W-1:0]   ch_data [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the output register must hold after the most recent edge.
  logic           m_valid = 1'b0;
  logic [W-1:0]   m_data  = '0;
  int             m_chan  = 0;
  int             m_ptr   = 0;

  stream_mux_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .man_en    (man_en),
    .man_sel   (man_sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign in_data[gi*W +: W] = ch_data[gi];
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit valid_bit(input int ch);
    logic [N-1:0] v;
    v = in_valid >> ch;
    return v[0];
  endfunction

  // Which channel the rules say must be granted right now (-1 for none).
  function automatic int model_grant();
    int order[$];
    int start;
    if (man_en)
      return (int'(man_sel) < N && valid_bit(int'(man_sel))) ? int'(man_sel) : -1;
    start = RR ? m_ptr : 0;
    for (int k = 0; k < N; k++) order.push_back((start + k) % N);
    foreach (order[j]) if (valid_bit(order[j])) return order[j];
    return -1;
  endfunction

  // Single compare process: checks outputs on every falling edge, then advances the model.
  always @(negedge clk) begin
    int           g;
    bit           load;
    logic [N-1:0] exp_ready;
    g         = model_grant();
    load      = !m_valid || out_ready;
    exp_ready = '0;
    if (!rst && load && g >= 0) exp_ready = N'(1) << g;

    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_chan",  32'(out_chan),  32'(m_chan));
    check("in_ready",  32'(in_ready),  32'(exp_ready));
    if (out_valid && out_ready && !rst)
      $display("xfer t=%0t chan=%0d data=%02h", $time, out_chan, out_data);

    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
    end else if (load && g >= 0) begin
      m_valid = 1'b1;
      m_data  = ch_data[CW'(g)];
      m_chan  = g;
      if (!man_en) m_ptr = (g + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input int chan, input logic [W-1:0] data);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".chan"},  32'(out_chan),  32'(chan));
    check({name, ".data"},  32'(out_data),  32'(data));
  endtask

  initial begin
    rst = 1'b1; man_en = 1'b0; man_sel = '0; out_ready = 1'b1;
    in_valid = '1;
    for (int i = 0; i < N; i++) ch_data[i] = W'(8'hA0 + i);

    // Reset with every channel requesting.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.data",  32'(out_data),  32'd0);
      check("rst.chan",  32'(out_chan),  32'd0);
      check("rst.ready", 32'(in_ready),  32'd0);
    end
    rst = 1'b0;

    // Full-load sweep.
    for (int k = 0; k <= N; k++) begin
      int ec;
      tick();
      ec = RR ? (k % N) : 0;
      check_out("sweep", ec, W'(8'hA0 + ec));
    end

    // Backpressure hold, then refill without a bubble.
    ch_data[3] = 8'h3C;
    in_valid   = N'(1) << 3;
    tick();
    check_out("bp.load", 3, 8'h3C);
    out_ready = 1'b0;
    in_valid  = N'(1) << 7;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_out("bp.hold", 3, 8'h3C);
      check("bp.ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check_out("bp.refill", 7, 8'hA7);

    // Pointer wrap.
    in_valid = N'(1) << 15;
    tick();
    check_out("wrap.15", 15, 8'hAF);
    in_valid = N'(1) << 2;
    tick();
    check_out("wrap.2", 2, 8'hA2);
    in_valid = (N'(1) << 1) | (N'(1) << 3);
    tick();
    check_out("wrap.1v3", RR ? 3 : 1, RR ? 8'h3C : 8'hA1);

    // Manual select.
    man_en = 1'b1; man_sel = CW'(5);
    in_valid = (N'(1) << 3) | (N'(1) << 5);
    #1 check("man.ready", 32'(in_ready), 32'h20);
    tick();
    check_out("man.5", 5, 8'hA5);
    in_valid = N'(1) << 3;
    #1 check("man.noready", 32'(in_ready), 32'd0);
    tick();
    check("man.idle", 32'(out_valid), 32'd0);
    man_en = 1'b0;
    in_valid = (N'(1) << 4) | (N'(1) << 6);
    tick();
    check_out("man.ptr", 4, 8'hA4);

    // Reset while holding a word under backpressure.
    out_ready = 1'b0;
    in_valid  = '1;
    tick();
    check("mid.held", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 check("mid.ready", 32'(in_ready), 32'd0);
    tick();
    check("mid.valid", 32'(out_valid), 32'd0);
    check("mid.chan",  32'(out_chan),  32'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check_out("mid.restart", 0, 8'hA0);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      man_en    = ($urandom_range(0, 7) == 0);
      man_sel   = CW'($urandom);
      in_valid  = (c % 3 == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      for (int i = 0; i < N; i++) ch_data[i] = W'($urandom);
      tick();
    end

    rst = 1'b0; in_valid = '0; out_ready = 1'b1; man_en = 1'b0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
